mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified memory between two requesters: instruction fetch (if_*) and load/store data (dm_*).
- Arbitrates round-robin and range/alignment-checks each request.
- Drives the memory's address/data_in/access_size/rw/enable for each beat, honours mem_busy, and returns read data beat by beat.
- Sits between the pipeline front-end/MEM stage and the memory instance.

Parameters:
- START_ADDR, 32'h80020000, first valid byte address.
- DEPTH, 1048576, memory size in bytes.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, address width.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- if_req, dm_req  in  1  request; held high until that port's done or err.
- if_addr, dm_addr  in  32  byte start address; stable while req.
- if_rw, dm_rw  in  1  1=read, 0=write (memory rw encoding); if_rw is tied 1 by users.
- if_size, dm_size  in  2  beats: 00=1, 01=4, 10=8, 11=16.
- if_wdata, dm_wdata  in  32  write data for the current beat.
- if_gnt, dm_gnt  out  1  port owns memory.
- if_wready, dm_wready  out  1  write beat accepted this cycle; requester advances wdata.
- if_rdata, dm_rdata  out  32  read beat data.
- if_rvalid, dm_rvalid  out  1  rdata valid.
- if_done, dm_done  out  1  1-cycle transaction-complete pulse.
- if_err, dm_err  out  1  1-cycle rejection pulse.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory data_in.
- mem_access_size  out  2  to memory access_size; copy of owner size.
- mem_rw  out  1  to memory rw.
- mem_enable  out  1  to memory enable.
- mem_busy  in  1  from memory busy.
- mem_data_out  in  32  from memory data_out.

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, priority pointer = fetch. All outputs 0: gnt, wready, rvalid, done, err, mem_enable, mem_rw, mem_access_size, mem_address, mem_data_in, rdata. Pending-read flag and beat counter cleared.
- Reset mid-burst aborts immediately. No further enable/rvalid/done. Requesters must re-request.
- States:
  - IDLE: if no req, stay.
    - Winner selection: the only requester; on a tie, the port named by the priority pointer.
    - Legality check: addr[1:0]==0, addr>=START_ADDR, and addr+4*beats <= START_ADDR+DEPTH (33-bit compare, no wrap).
    - Illegal → ERR. Legal → latch owner/addr/rw/size, beat counter=0, → BEAT.
  - ERR (1 cycle): err=1 to winner, no mem_enable, pointer flips to the other port, → IDLE.
  - BEAT: gnt=1, mem_enable=1, mem_address=base+4*beat, mem_rw/mem_access_size from latch, mem_data_in=owner wdata (writes).
    - A beat is accepted when mem_busy=0. Then: beat++; wready=1 for writes; for reads, set the pending flag.
    - If mem_busy=1: hold all mem outputs, no wready, counter unchanged.
    - On accepting the last beat: write → DONE; read → RLAST.
  - Read return (any state): in the cycle after each accepted read beat, rvalid=1 and rdata=mem_data_out, to the owner only.
  - RLAST (1 cycle): mem_enable=0, last rvalid, done=1 in the same cycle → IDLE; pointer flips.
  - DONE (writes, 1 cycle): mem_enable=0, done=1, gnt=1 → IDLE; pointer flips.
- gnt is high from the first BEAT cycle through the done cycle inclusive; low in IDLE/ERR.
- Latency, uncontended, no busy:
  - N-beat read: req seen at edge k; beats in cycles k+1..k+N; rvalid in cycles k+2..k+N+1; done in cycle k+N+1.
  - N-beat write: done in cycle k+N+1.
- Requests arriving while another port owns memory wait; no preemption.
- The owner's req dropping mid-burst is a protocol violation; the burst still completes.
- Attributes are latched at grant; changes to addr/size/rw after grant are ignored.

Test Plan:
- Single fetch read: if_req, addr 0x80020000, size 00, mem returns 0x27BDFFE8, no busy → mem_enable one cycle with addr 0x80020000, rw=1; next cycle if_rvalid=1, if_rdata=0x27BDFFE8, if_done=1; dm outputs stay 0.
- Tie after reset: if_req and dm_req both high, single reads → fetch granted first, data second. Repeat the tie → data first (alternation).
- 4-beat write: dm addr 0x80020010, size 01, wdata 1,2,3,4 → mem_address 0x80020010/14/18/1C, rw=0, four dm_wready pulses, mem_data_in 1..4; dm_done the cycle after beat 4.
- Busy stall: 4-beat read at 0x80020100, mem_busy high 3 cycles on beat 2 → address 0x80020104 held 4 cycles; exactly 4 rvalid pulses; done 3 cycles later than unstalled.
- Illegal requests, each → dm_err pulse only, mem_enable never asserted:
  - addr 0x80000000
  - addr 0x80020002
  - size 11 at 0x8011FFF0 (crosses 0x80120000)
- Reset mid-burst: reset_n low during beat 3 of an 8-beat read → next cycle all outputs 0. A subsequent legal request completes normally with fetch priority.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory between instruction fetch (if_*) and
//   load/store data (dm_*). Arbitration is round-robin. Each request is
//   range/alignment checked, then issued as a burst of word beats.
//   The memory's busy signal stalls the burst. Read data is handed back
//   to the owning port one cycle after each accepted beat.
//
// Ports
//   clock, reset_n          single clock, synchronous active-low reset
//   if_*/dm_* requests      req, addr, rw (1=read), size (beats 1/4/8/16), wdata
//   if_*/dm_* responses     gnt, wready, rdata, rvalid, done, err
//   mem_*                   address, data_in, access_size, rw, enable to memory;
//                           busy, data_out from memory
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; pick a winner and check legality
// ERR    | one-cycle err pulse to the rejected requester
// BEAT   | owner holds memory; one beat per cycle while mem_busy is low
// RLAST  | read burst finished; last rvalid and done together
// DONE   | write burst finished; done pulse
module mem_port_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000,
  parameter int unsigned           DEPTH      = 1048576
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_rw,
  input  logic [1:0]            if_size,
  input  logic [DATA_WIDTH-1:0] if_wdata,
  input  logic                  dm_req,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rw,
  input  logic [1:0]            dm_size,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  if_gnt,
  output logic                  if_wready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  output logic                  if_done,
  output logic                  if_err,
  output logic                  dm_gnt,
  output logic                  dm_wready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_rvalid,
  output logic                  dm_done,
  output logic                  dm_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_BEAT  = 3'd2,
    S_RLAST = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One past the last valid byte, kept one bit wider so the end-of-burst
  // compare cannot wrap.
  localparam logic [ADDR_WIDTH:0] LP_END = {1'b0, START_ADDR} + {1'b0, DEPTH};

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_ptr;      // 0 = fetch has priority on a tie, 1 = data
  logic                  r_owner;    // 0 = fetch, 1 = data
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_rw;
  logic [1:0]            r_size;
  logic [4:0]            r_beat;
  logic                  r_rd_pend;  // a read beat was accepted last cycle

  logic                  w_any_req;
  logic                  w_pick_dm;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_req_rw;
  logic [1:0]            w_req_size;
  logic [6:0]            w_req_bytes;
  logic [ADDR_WIDTH:0]   w_req_end;
  logic                  w_legal;
  logic [4:0]            w_last_idx;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_offset;

  // Winner selection and legality of the winner's request
  assign w_any_req = if_req | dm_req;

  always_comb begin
    w_pick_dm = 1'b0;
    if (dm_req && !if_req) begin
      w_pick_dm = 1'b1;
    end else if (dm_req && if_req) begin
      w_pick_dm = r_ptr;
    end
  end

  assign w_req_addr = w_pick_dm ? dm_addr : if_addr;
  assign w_req_rw   = w_pick_dm ? dm_rw   : if_rw;
  assign w_req_size = w_pick_dm ? dm_size : if_size;

  always_comb begin
    w_req_bytes = 7'd4;
    case (w_req_size)
      2'b00:   w_req_bytes = 7'd4;
      2'b01:   w_req_bytes = 7'd16;
      2'b10:   w_req_bytes = 7'd32;
      default: w_req_bytes = 7'd64;
    endcase
  end

  assign w_req_end = {1'b0, w_req_addr} + {{(ADDR_WIDTH-6){1'b0}}, w_req_bytes};
  assign w_legal   = (w_req_addr[1:0] == 2'b00) &&
                     (w_req_addr >= START_ADDR) &&
                     (w_req_end <= LP_END);

  // Burst progress
  always_comb begin
    w_last_idx = 5'd0;
    case (r_size)
      2'b00:   w_last_idx = 5'd0;
      2'b01:   w_last_idx = 5'd3;
      2'b10:   w_last_idx = 5'd7;
      default: w_last_idx = 5'd15;
    endcase
  end

  assign w_accept    = (r_state == S_BEAT) && !mem_busy;
  assign w_last_beat = (r_beat == w_last_idx);
  assign w_offset    = {{(ADDR_WIDTH-7){1'b0}}, r_beat, 2'b00};

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_legal ? S_BEAT : S_ERR;
        end
      end
      S_ERR:   w_state_nxt = S_IDLE;
      S_BEAT: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = r_rw ? S_RLAST : S_DONE;
        end
      end
      S_RLAST: w_state_nxt = S_IDLE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latched transaction attributes, beat counter, priority pointer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_base    <= '0;
      r_rw      <= 1'b0;
      r_size    <= 2'b00;
      r_beat    <= 5'd0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_accept && r_rw;
      case (r_state)
        S_IDLE: begin
          // The owner is latched even for a rejected request so ERR
          // knows which port to flag.
          if (w_any_req) begin
            r_owner <= w_pick_dm;
            r_base  <= w_req_addr;
            r_rw    <= w_req_rw;
            r_size  <= w_req_size;
            r_beat  <= 5'd0;
          end
        end
        S_BEAT: begin
          if (w_accept) begin
            r_beat <= r_beat + 5'd1;
          end
        end
        S_ERR, S_RLAST, S_DONE: r_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    if_gnt          = 1'b0;
    dm_gnt          = 1'b0;
    if_wready       = 1'b0;
    dm_wready       = 1'b0;
    if_rvalid       = 1'b0;
    dm_rvalid       = 1'b0;
    if_rdata        = '0;
    dm_rdata        = '0;
    if_done         = 1'b0;
    dm_done         = 1'b0;
    if_err          = 1'b0;
    dm_err          = 1'b0;
    mem_enable      = 1'b0;
    mem_rw          = 1'b0;
    mem_access_size = 2'b00;
    mem_address     = '0;
    mem_data_in     = '0;

    case (r_state)
      S_ERR: begin
        if_err = ~r_owner;
        dm_err = r_owner;
      end
      S_BEAT: begin
        if_gnt          = ~r_owner;
        dm_gnt          = r_owner;
        mem_enable      = 1'b1;
        mem_rw          = r_rw;
        mem_access_size = r_size;
        mem_address     = r_base + w_offset;
        if (!r_rw) begin
          mem_data_in = r_owner ? dm_wdata : if_wdata;
          if_wready   = w_accept && !r_owner;
          dm_wready   = w_accept && r_owner;
        end
      end
      S_RLAST, S_DONE: begin
        if_gnt  = ~r_owner;
        dm_gnt  = r_owner;
        if_done = ~r_owner;
        dm_done = r_owner;
      end
      default: ;
    endcase

    // Read data comes back the cycle after its beat, whatever the state.
    if (r_rd_pend) begin
      if (r_owner) begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_data_out;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req, dm_req;
  logic [31:0] if_addr, dm_addr;
  logic        if_rw, dm_rw;
  logic [1:0]  if_size, dm_size;
  logic [31:0] if_wdata, dm_wdata;
  logic        if_gnt, if_wready, if_rvalid, if_done, if_err;
  logic        dm_gnt, dm_wready, dm_rvalid, dm_done, dm_err;
  logic [31:0] if_rdata, dm_rdata;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable, mem_busy;
  logic [31:0] mem_data_out;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rw(if_rw), .if_size(if_size), .if_wdata(if_wdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_rw(dm_rw), .dm_size(dm_size), .dm_wdata(dm_wdata),
    .if_gnt(if_gnt), .if_wready(if_wready), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .if_done(if_done), .if_err(if_err),
    .dm_gnt(dm_gnt), .dm_wready(dm_wready), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .dm_done(dm_done), .dm_err(dm_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [15:0] w_ctl;
  assign w_ctl = {if_gnt, dm_gnt, if_wready, dm_wready, if_rvalid, dm_rvalid,
                  if_done, dm_done, if_err, dm_err, mem_enable, mem_rw, mem_access_size, 2'b00};

  // Memory: registered read data, a fixed word at the base, ~addr elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h80020000) ? 32'h27BDFFE8 : ~a;
  endfunction

  logic        cap_en;
  logic [31:0] cap_addr;
  always @(negedge clock) begin
    cap_en   = mem_enable & ~mem_busy & mem_rw;
    cap_addr = mem_address;
  end
  always @(posedge clock) if (cap_en) mem_data_out <= mem_fn(cap_addr);

  // Monitor
  int          en_cnt, first_en, wr_cnt, rv_if_n, rv_dm_n, done_n, done_cyc;
  int          err_if, err_dm, gnt_seen, dm_act, gnt_at_done, rv_at_done, rw_or, sz_last;
  int          wr_seen;
  int          done_log[8];
  logic [31:0] addr_log[64], wdat_log[64], rv_if_log[64], rv_dm_log[64];

  task automatic mon_clear();
    en_cnt = 0; first_en = -1; wr_cnt = 0; rv_if_n = 0; rv_dm_n = 0; done_n = 0;
    done_cyc = -1; err_if = 0; err_dm = 0; gnt_seen = 0; dm_act = 0;
    gnt_at_done = 0; rv_at_done = 0; rw_or = 0; sz_last = 0;
    for (int i = 0; i < 8; i++) done_log[i] = -1;
  endtask

  always @(negedge clock) begin
    if (mem_enable) begin
      if (en_cnt == 0) first_en = cyc;
      if (en_cnt < 64) addr_log[en_cnt] = mem_address;
      en_cnt++;
      rw_or   = rw_or | int'(mem_rw);
      sz_last = int'(mem_access_size);
    end
    wr_seen = int'(dm_wready);
    if (dm_wready) begin
      if (wr_cnt < 64) wdat_log[wr_cnt] = mem_data_in;
      wr_cnt++;
    end
    if (if_rvalid) begin
      if (rv_if_n < 64) rv_if_log[rv_if_n] = if_rdata;
      rv_if_n++;
    end
    if (dm_rvalid) begin
      if (rv_dm_n < 64) rv_dm_log[rv_dm_n] = dm_rdata;
      rv_dm_n++;
    end
    if (if_done) begin
      if (done_n < 8) done_log[done_n] = 0;
      done_n++; done_cyc = cyc; gnt_at_done = int'(if_gnt); rv_at_done = int'(if_rvalid);
    end
    if (dm_done) begin
      if (done_n < 8) done_log[done_n] = 1;
      done_n++; done_cyc = cyc; gnt_at_done = int'(dm_gnt); rv_at_done = int'(dm_rvalid);
    end
    if (if_err) err_if++;
    if (dm_err) err_dm++;
    if (if_gnt | dm_gnt) gnt_seen = 1;
    if (dm_gnt | dm_wready | dm_rvalid | dm_done | dm_err | (dm_rdata != 0)) dm_act = 1;
  end

  // Write requester advances wdata after each accepted beat.
  int wr_auto = 0;
  always @(posedge clock) begin
    #1;
    if (wr_auto != 0 && wr_seen != 0) dm_wdata = dm_wdata + 1;
  end

  // Memory busy window: three cycles starting at cycle busy_from.
  int busy_on = 0;
  int busy_from = 0;
  always @(posedge clock) begin
    #1;
    mem_busy = (busy_on != 0) && (cyc >= busy_from) && (cyc < busy_from + 3);
  end

  task automatic wait_evt(input int n, input string tag);
    int t;
    t = 0;
    while ((done_n + err_if + err_dm) < n && t < 200) begin
      @(negedge clock); #1;
      t++;
    end
    chk({tag, "_events"}, done_n + err_if + err_dm, n);
  endtask

  task automatic reset_dut();
    @(posedge clock); #1;
    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  logic [31:0] ill_addr[4];
  logic [1:0]  ill_size[4];
  int          ill_ok[4];
  int          c0, n104;

  initial begin
    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0;
    if_rw = 1'b1; dm_rw = 1'b1; if_size = 2'b00; dm_size = 2'b00;
    if_wdata = '0; dm_wdata = '0; mem_busy = 1'b0; mem_data_out = '0;
    mon_clear();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_ctl", 32'(w_ctl), 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_din", mem_data_in, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Single fetch read
    mon_clear();
    @(posedge clock); #1;
    c0 = cyc; if_addr = 32'h80020000; if_size = 2'b00; if_req = 1'b1;
    wait_evt(1, "t1");
    @(posedge clock); #1 if_req = 1'b0;
    chk("t1_en_cnt", en_cnt, 1);
    chk("t1_first_en", first_en, c0 + 1);
    chk("t1_addr", addr_log[0], 32'h80020000);
    chk("t1_rw", rw_or, 1);
    chk("t1_rv_cnt", rv_if_n, 1);
    chk("t1_rdata", rv_if_log[0], 32'h27BDFFE8);
    chk("t1_done_cyc", done_cyc, first_en + 1);
    chk("t1_rv_at_done", rv_at_done, 1);
    chk("t1_dm_quiet", dm_act, 0);

    // Tie after reset, both held: fetch, data, fetch
    reset_dut();
    mon_clear();
    @(posedge clock); #1;
    if_addr = 32'h80020040; if_size = 2'b00;
    dm_addr = 32'h80020080; dm_size = 2'b00; dm_rw = 1'b1;
    if_req = 1'b1; dm_req = 1'b1;
    wait_evt(3, "t2");
    @(posedge clock); #1 if_req = 1'b0; dm_req = 1'b0;
    chk("t2_order0", done_log[0], 0);
    chk("t2_order1", done_log[1], 1);
    chk("t2_order2", done_log[2], 0);
    chk("t2_rv_if_n", rv_if_n, 2);
    chk("t2_rv_dm_n", rv_dm_n, 1);
    chk("t2_if_data", rv_if_log[0], 32'h7FFDFFBF);
    chk("t2_dm_data", rv_dm_log[0], 32'h7FFDFF7F);

    // 4-beat data write
    mon_clear();
    @(posedge clock); #1;
    dm_addr = 32'h80020010; dm_size = 2'b01; dm_rw = 1'b0; dm_wdata = 32'd1;
    wr_auto = 1; dm_req = 1'b1;
    wait_evt(1, "t3");
    @(posedge clock); #1 dm_req = 1'b0; wr_auto = 0; dm_rw = 1'b1;
    chk("t3_en_cnt", en_cnt, 4);
    chk("t3_wr_cnt", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), addr_log[i], 32'h80020010 + 32'(4 * i));
      chk($sformatf("t3_wdata%0d", i), wdat_log[i], 32'(i + 1));
    end
    chk("t3_rw", rw_or, 0);
    chk("t3_size", sz_last, 1);
    chk("t3_done_cyc", done_cyc, first_en + 4);
    chk("t3_gnt_at_done", gnt_at_done, 1);
    chk("t3_done_port", done_log[0], 1);

    // 4-beat fetch read, memory busy 3 cycles on beat 2
    mon_clear();
    @(posedge clock); #1;
    c0 = cyc; busy_from = c0 + 2; busy_on = 1;
    if_addr = 32'h80020100; if_size = 2'b01; if_req = 1'b1;
    wait_evt(1, "t4");
    @(posedge clock); #1 if_req = 1'b0; busy_on = 0;
    n104 = 0;
    for (int i = 0; i < 7; i++) if (addr_log[i] == 32'h80020104) n104++;
    chk("t4_hold_cnt", n104, 4);
    chk("t4_en_cnt", en_cnt, 7);
    chk("t4_rv_cnt", rv_if_n, 4);
    chk("t4_rdata0", rv_if_log[0], 32'h7FFDFEFF);
    chk("t4_rdata1", rv_if_log[1], 32'h7FFDFEFB);
    chk("t4_rdata3", rv_if_log[3], 32'h7FFDFEF3);
    chk("t4_done_cyc", done_cyc, first_en + 7);

    // Range/alignment: three rejects and one burst ending exactly at the top
    ill_addr[0] = 32'h80000000; ill_size[0] = 2'b00; ill_ok[0] = 0;
    ill_addr[1] = 32'h80020002; ill_size[1] = 2'b00; ill_ok[1] = 0;
    ill_addr[2] = 32'h8011FFF0; ill_size[2] = 2'b11; ill_ok[2] = 0;
    ill_addr[3] = 32'h8011FFC0; ill_size[3] = 2'b11; ill_ok[3] = 1;
    for (int v = 0; v < 4; v++) begin
      mon_clear();
      @(posedge clock); #1;
      dm_addr = ill_addr[v]; dm_size = ill_size[v]; dm_rw = 1'b1; dm_req = 1'b1;
      wait_evt(1, $sformatf("t5_%0d", v));
      @(posedge clock); #1 dm_req = 1'b0;
      chk($sformatf("t5_%0d_err", v), err_dm, (ill_ok[v] != 0) ? 0 : 1);
      chk($sformatf("t5_%0d_en", v), en_cnt, (ill_ok[v] != 0) ? 16 : 0);
      chk($sformatf("t5_%0d_gnt", v), gnt_seen, ill_ok[v]);
      chk($sformatf("t5_%0d_iferr", v), err_if, 0);
    end
    chk("t5_top_last_addr", addr_log[15], 32'h8011FFFC);

    // Reset during beat 3 of an 8-beat fetch read
    reset_dut();
    mon_clear();
    @(posedge clock); #1;
    if_addr = 32'h80020200; if_size = 2'b10; if_req = 1'b1;
    for (int t = 0; t < 50 && en_cnt < 3; t++) begin
      @(negedge clock); #1;
    end
    chk("t6_reach_beat3", en_cnt, 3);
    reset_n = 1'b0; if_req = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    chk("t6_rst_ctl", 32'(w_ctl), 32'h0);
    chk("t6_rst_addr", mem_address, 32'h0);
    chk("t6_rst_rdata", if_rdata | dm_rdata, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    chk("t6_no_more_en", en_cnt, 3);
    chk("t6_rv_cnt", rv_if_n, 2);
    chk("t6_no_done", done_n, 0);
    mon_clear();
    @(posedge clock); #1;
    if_addr = 32'h80020300; if_size = 2'b00;
    dm_addr = 32'h80020304; dm_size = 2'b00; dm_rw = 1'b1;
    if_req = 1'b1; dm_req = 1'b1;
    wait_evt(1, "t6b");
    @(posedge clock); #1 if_req = 1'b0; dm_req = 1'b0;
    chk("t6_prio_fetch", done_log[0], 0);
    chk("t6_if_data", rv_if_log[0], 32'h7FFDFCFF);
    chk("t6_dm_rv", rv_dm_n, 0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
